// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and encodings for the RV32I single-cycle execute core.
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef logic [31:0] Word;
    typedef logic [4:0]  RegAddress;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } AluOp;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam Word EBREAK_INSTR = 32'h0010_0073;

    typedef struct packed {
        AluOp      op;
        RegAddress rd;
        RegAddress rs1;
        RegAddress rs2;
        logic      has_imm;
        Word       imm;
        logic      ebreak;
        logic      illegal;
    } Instruction;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Brief  : RV32I integer ALU; shifts use the low 5 bits of operand B.
// Rev    : 1.0 - initial release
// ============================================================================
module alu
    import cpu_pkg::*;
(
    input  AluOp i_op,
    input  Word  i_a,
    input  Word  i_b,
    output Word  o_y
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD:  o_y = i_a + i_b;
            ALU_SUB:  o_y = i_a - i_b;
            ALU_SLL:  o_y = i_a << w_shamt;
            ALU_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_y = {31'b0, i_a < i_b};
            ALU_XOR:  o_y = i_a ^ i_b;
            ALU_SRL:  o_y = i_a >> w_shamt;
            ALU_SRA:  o_y = Word'($signed(i_a) >>> w_shamt);
            ALU_OR:   o_y = i_a | i_b;
            ALU_AND:  o_y = i_a & i_b;
            default:  o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module : instruction_decoder
// Brief  : Raw RV32 word -> decoded Instruction for the supported OP/OP-IMM/EBREAK set.
// Rev    : 1.0 - initial release
// ============================================================================
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output Instruction  o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        o_dec         = '0;
        o_dec.op      = ALU_ADD;
        o_dec.rd      = i_instr[11:7];
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.imm     = {{20{i_instr[31]}}, i_instr[31:20]};
        o_dec.illegal = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                o_dec.illegal = 1'b0;
                case (w_funct3)
                    F3_ADD:  o_dec.op = (w_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  o_dec.op = ALU_SLL;
                    F3_SLT:  o_dec.op = ALU_SLT;
                    F3_SLTU: o_dec.op = ALU_SLTU;
                    F3_XOR:  o_dec.op = ALU_XOR;
                    F3_SR:   o_dec.op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:   o_dec.op = ALU_OR;
                    F3_AND:  o_dec.op = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA accept the alternate funct7.
                if (w_funct7 != F7_ZERO &&
                    !(w_funct7 == F7_ALT && (w_funct3 == F3_ADD || w_funct3 == F3_SR)))
                    o_dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                o_dec.illegal = 1'b0;
                o_dec.has_imm = 1'b1;
                case (w_funct3)
                    F3_ADD:  o_dec.op = ALU_ADD;
                    F3_SLL: begin
                        o_dec.op      = ALU_SLL;
                        o_dec.illegal = (w_funct7 != F7_ZERO);
                    end
                    F3_SLT:  o_dec.op = ALU_SLT;
                    F3_SLTU: o_dec.op = ALU_SLTU;
                    F3_XOR:  o_dec.op = ALU_XOR;
                    F3_SR: begin
                        o_dec.op      = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        o_dec.illegal = (w_funct7 != F7_ZERO) && (w_funct7 != F7_ALT);
                    end
                    F3_OR:   o_dec.op = ALU_OR;
                    F3_AND:  o_dec.op = ALU_AND;
                endcase
            end
            OPC_SYSTEM: begin
                if (i_instr == EBREAK_INSTR) begin
                    o_dec.ebreak  = 1'b1;
                    o_dec.illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module : register_file
// Brief  : 2R+1W+debug-read register file, x0 hardwired to zero, async clear.
// Rev    : 1.0 - initial release
// ============================================================================
module register_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  RegAddress       i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  RegAddress       i_raddr_a,
    output logic [XLEN-1:0] o_rdata_a,
    input  RegAddress       i_raddr_b,
    output logic [XLEN-1:0] o_rdata_b,
    input  RegAddress       i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_data
);

    logic [XLEN-1:0] w_view [NREGS];

    assign w_view[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic [XLEN-1:0] data_q;
        logic [XLEN-1:0] data_d;

        always_comb begin
            data_d = data_q;
            if (i_we && i_waddr == RegAddress'(i))
                data_d = i_wdata;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) data_q <= '0;
            else        data_q <= data_d;
        end

        assign w_view[i] = data_q;
    end

    assign o_rdata_a  = w_view[i_raddr_a];
    assign o_rdata_b  = w_view[i_raddr_b];
    assign o_dbg_data = w_view[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module : cpu_core
// Brief  : Single-cycle RV32I execute core: decoder + register file + ALU + halt flag.
// Rev    : 1.0 - initial release
// ============================================================================
module cpu_core
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] result,
    output logic            ebreak,
    output logic            illegal,
    output logic            halted,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    Instruction w_dec;
    Word        w_rs1_data;
    Word        w_rs2_data;
    Word        w_op_b;
    Word        w_alu_y;
    logic       w_alu_valid;
    logic       w_we;
    logic       halted_q;
    logic       halted_d;

    instruction_decoder u_dec (
        .i_instr (instr),
        .o_dec   (w_dec)
    );

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_dec.rd),
        .i_wdata    (result),
        .i_raddr_a  (w_dec.rs1),
        .o_rdata_a  (w_rs1_data),
        .i_raddr_b  (w_dec.rs2),
        .o_rdata_b  (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    assign w_op_b = w_dec.has_imm ? w_dec.imm : w_rs2_data;

    alu u_alu (
        .i_op (w_dec.op),
        .i_a  (w_rs1_data),
        .i_b  (w_op_b),
        .o_y  (w_alu_y)
    );

    // EBREAK and illegal words report a zero result and never write back.
    assign w_alu_valid = !w_dec.illegal && !w_dec.ebreak;
    assign result      = w_alu_valid ? w_alu_y : '0;
    assign w_we        = w_alu_valid && (w_dec.rd != '0) && !halted_q;
    assign ebreak      = w_dec.ebreak;
    assign illegal     = w_dec.illegal;

    always_comb begin
        halted_d = halted_q | w_dec.ebreak;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halted = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_core
// Brief  : Scoreboard bench for cpu_core; expectations queued at drive time.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] result;
    logic        ebreak;
    logic        illegal;
    logic        halted;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    cpu_core #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .result   (result),
        .ebreak   (ebreak),
        .illegal  (illegal),
        .halted   (halted),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_RESULT, K_ILLEGAL, K_EBREAK, K_HALTED, K_DBG} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void expect_val(input string tag, input kind_e kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RESULT:  obs = result;
                K_ILLEGAL: obs = {31'b0, illegal};
                K_EBREAK:  obs = {31'b0, ebreak};
                K_HALTED:  obs = {31'b0, halted};
                default:   obs = dbg_data;
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic exec_full(input string tag, input logic [31:0] ins, input logic [31:0] res,
                             input logic ill, input logic ebk);
        @(negedge clk);
        instr = ins;
        expect_val({tag, ".result"},  K_RESULT,  res);
        expect_val({tag, ".illegal"}, K_ILLEGAL, {31'b0, ill});
        expect_val({tag, ".ebreak"},  K_EBREAK,  {31'b0, ebk});
        #1 drain();
    endtask

    task automatic exec(input string tag, input logic [31:0] ins, input logic [31:0] res);
        exec_full(tag, ins, res, 1'b0, 1'b0);
    endtask

    task automatic peek_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        @(negedge clk);
        instr    = C_NOP;
        dbg_addr = addr;
        expect_val(tag, K_DBG, exp);
        #1 drain();
    endtask

    task automatic peek_halted(input string tag, input logic exp);
        @(negedge clk);
        instr = C_NOP;
        expect_val(tag, K_HALTED, {31'b0, exp});
        #1 drain();
    endtask

    // Pulse reset between clock edges and confirm its effect before the next edge.
    task automatic async_reset(input string tag, input logic [4:0] addr);
        @(negedge clk);
        instr    = C_NOP;
        dbg_addr = addr;
        #1 rst_n = 1'b0;
        #1;
        expect_val({tag, ".dbg"},    K_DBG,    32'h0);
        expect_val({tag, ".halted"}, K_HALTED, 32'h0);
        drain();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = C_NOP;
        dbg_addr = 5'd1;
        #3;
        expect_val("rst.halted", K_HALTED, 32'h0);
        expect_val("rst.x1",     K_DBG,    32'h0);
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Dependent ADDI chain
        exec("addi1", enc_i(3'b000, 5'd1, 5'd0, 12'd10), 32'd10);
        exec("addi2", enc_i(3'b000, 5'd1, 5'd1, 12'd40), 32'd50);
        exec("addi3", enc_i(3'b000, 5'd2, 5'd1, 12'd10), 32'd60);
        exec("addi4", enc_i(3'b000, 5'd3, 5'd2, 12'd1),  32'd61);
        exec("addi5", enc_i(3'b000, 5'd4, 5'd3, 12'd1),  32'd62);
        peek_reg("x1", 5'd1, 32'd50);
        peek_reg("x2", 5'd2, 32'd60);
        peek_reg("x3", 5'd3, 32'd61);
        peek_reg("x4", 5'd4, 32'd62);

        // SUB / AND, then EBREAK halts and blocks later writes
        exec("sub", enc_r(7'h20, 3'b000, 5'd5, 5'd4, 5'd1), 32'd12);
        exec("and", enc_r(7'h00, 3'b111, 5'd6, 5'd1, 5'd2), 32'd48);
        peek_reg("x5", 5'd5, 32'd12);
        peek_reg("x6", 5'd6, 32'd48);
        peek_halted("halt.pre", 1'b0);
        exec_full("ebreak", C_EBREAK, 32'h0, 1'b0, 1'b1);
        exec("addi.halted", enc_i(3'b000, 5'd7, 5'd0, 12'd5), 32'd5);
        peek_halted("halt.post", 1'b1);
        peek_reg("x7.halted", 5'd7, 32'd0);

        async_reset("rst.halted_run", 5'd1);

        // x0 and signed/unsigned boundaries
        exec("addi.x0", enc_i(3'b000, 5'd0, 5'd0, 12'd7), 32'd7);
        peek_reg("x0", 5'd0, 32'd0);
        exec("addi.m1", enc_i(3'b000, 5'd8, 5'd0, 12'hFFF), 32'hFFFF_FFFF);
        peek_reg("x8", 5'd8, 32'hFFFF_FFFF);
        exec("slti",  enc_i(3'b010, 5'd9, 5'd8, 12'd0), 32'd1);
        peek_reg("x9.slti", 5'd9, 32'd1);
        exec("sltiu", enc_i(3'b011, 5'd9, 5'd8, 12'd0), 32'd0);
        peek_reg("x9.sltiu", 5'd9, 32'd0);
        exec("srai", enc_i(3'b101, 5'd10, 5'd8, {7'h20, 5'd4}), 32'hFFFF_FFFF);
        exec("srli", enc_i(3'b101, 5'd11, 5'd8, {7'h00, 5'd4}), 32'h0FFF_FFFF);
        peek_reg("x11", 5'd11, 32'h0FFF_FFFF);

        // Overflow wrap and register-operand shifts/compares
        exec("srli1", enc_i(3'b101, 5'd12, 5'd8, {7'h00, 5'd1}), 32'h7FFF_FFFF);
        exec("ovf",   enc_i(3'b000, 5'd13, 5'd12, 12'd1),        32'h8000_0000);
        exec("x14",   enc_i(3'b000, 5'd14, 5'd0, 12'd33),        32'd33);
        exec("x15",   enc_i(3'b000, 5'd15, 5'd0, 12'd3),         32'd3);
        exec("sll33", enc_r(7'h00, 3'b001, 5'd16, 5'd15, 5'd14), 32'd6);
        exec("sra",   enc_r(7'h20, 3'b101, 5'd17, 5'd13, 5'd15), 32'hF000_0000);
        exec("srl",   enc_r(7'h00, 3'b101, 5'd22, 5'd13, 5'd15), 32'h1000_0000);
        exec("sltu",  enc_r(7'h00, 3'b011, 5'd18, 5'd0, 5'd13),  32'd1);
        exec("slt",   enc_r(7'h00, 3'b010, 5'd19, 5'd13, 5'd0),  32'd1);
        exec("xor",   enc_r(7'h00, 3'b100, 5'd20, 5'd8, 5'd12),  32'h8000_0000);
        exec("or",    enc_r(7'h00, 3'b110, 5'd21, 5'd15, 5'd14), 32'd35);
        peek_reg("x16", 5'd16, 32'd6);
        peek_reg("x17", 5'd17, 32'hF000_0000);

        // Illegal encodings leave state untouched
        exec_full("ill.ones", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        exec_full("ill.slli", enc_i(3'b001, 5'd13, 5'd13, {7'h20, 5'd1}), 32'h0, 1'b1, 1'b0);
        exec_full("ill.addf7", enc_r(7'h01, 3'b000, 5'd13, 5'd13, 5'd13), 32'h0, 1'b1, 1'b0);
        peek_reg("x13.kept", 5'd13, 32'h8000_0000);
        peek_halted("halt.none", 1'b0);

        async_reset("rst.midrun", 5'd13);
        exec("post_rst", enc_i(3'b000, 5'd1, 5'd0, 12'd9), 32'd9);
        peek_reg("x1.post_rst", 5'd1, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
